branch_cond_unit: RTL
=====================

BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 The block SHALL have parameter PC_W, default 32, giving the width of the program-counter and target buses.
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flag_valid  input  1  ALU presents a flag set.
REQ-005 flag_ready  output  1  block accepts the flag set.
REQ-006 rel_in  input  1  relational result bit from the ALU (1 = relation true).
REQ-007 n_in  input  1  ALU negative flag.
REQ-008 z_in  input  1  ALU zero flag.
REQ-009 br_valid  input  1  branch request present.
REQ-010 br_ready  output  1  block accepts the branch request.
REQ-011 br_cond  input  3  condition code.
REQ-012 br_target  input  PC_W  branch target address.
REQ-013 pc_in  input  PC_W  address of the branch instruction.
REQ-014 flush  input  1  synchronous abort.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts the result.
REQ-017 taken  output  1  branch decision.
REQ-018 next_pc  output  PC_W  resolved next address.
REQ-019 flags_q  output  3  stored flags {rel, n, z}.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, WAIT_FLAGS, EVAL and HOLD.
REQ-021 br_ready SHALL be 1 only in IDLE, and flag_ready SHALL be 1 only in IDLE and WAIT_FLAGS.
REQ-022 A flag handshake (flag_valid && flag_ready) SHALL load flags_q <= {rel_in, n_in, z_in} and set the internal flags_vld bit; flags_vld SHALL stay set until reset or flush.
REQ-023 On a branch handshake in IDLE the block SHALL latch br_cond, br_target and pc_in.
REQ-024 On that handshake it SHALL go to EVAL if flags_vld is 1 or a flag handshake occurs in the same cycle, otherwise to WAIT_FLAGS.
REQ-025 When a flag handshake and a branch handshake coincide, the newly captured flags SHALL be used for evaluation.
REQ-026 WAIT_FLAGS SHALL move to EVAL on the edge that captures a flag set.
REQ-027 EVAL SHALL last exactly one cycle, register taken and next_pc, then move to HOLD.
REQ-028 Conditions SHALL decode as: 000 always; 001 never; 010 rel; 011 !rel; 100 z; 101 !z; 110 n; 111 !n && !z.
REQ-029 next_pc SHALL be br_target when taken, else (pc_in + 4) truncated to PC_W bits (wrap-around, no carry out).
REQ-030 out_valid SHALL be 1 exactly in HOLD.
REQ-031 taken and next_pc SHALL stay stable while out_valid && !out_ready.
REQ-032 HOLD SHALL return to IDLE on out_valid && out_ready.
REQ-033 Latency: branch accepted at edge k with flags valid -> EVAL during cycle k..k+1 -> out_valid high from edge k+1 (one cycle after acceptance is EVAL, result visible the following cycle).
REQ-034 Flags arriving in EVAL or HOLD SHALL NOT be accepted (flag_ready = 0) and SHALL NOT alter an in-flight decision.
REQ-035 flush SHALL take priority over all handshakes and, at the next edge, set state to IDLE, clear out_valid and clear flags_vld.
REQ-036 flush SHALL leave taken, next_pc and flags_q unchanged, and SHALL ignore any branch or flag handshake offered in the same cycle.

Reset
REQ-037 While rst_n = 0 the block SHALL immediately force state IDLE, flags_q = 0, flags_vld = 0, out_valid = 0, taken = 0 and next_pc = 0.
REQ-038 As a consequence of REQ-037, br_ready = 1 and flag_ready = 1 during reset.
REQ-039 Reset asserted mid-operation (WAIT_FLAGS, EVAL or HOLD) SHALL discard the pending branch without producing an output.

Verification
REQ-040 Flags {1,0,0} loaded, then branch cond=010, pc=0x100, target=0x200 -> out_valid two cycles after acceptance, taken=1, next_pc=0x200.
REQ-041 Same flags, cond=011, pc=0xFFFFFFFC -> taken=0, next_pc=0x00000000 (wrap).
REQ-042 Branch cond=100 with no flags ever loaded -> WAIT_FLAGS with br_ready=0; flags {0,0,1} arrive 3 cycles later -> taken=1; out_ready held 0 for 4 cycles -> outputs stable, then a single handshake returns to IDLE.
REQ-043 Flag {0,1,0} and branch cond=110 offered in the same cycle with stale flags {0,0,1} stored -> the new flags are used, taken=1.
REQ-044 flush in HOLD -> out_valid=0 next cycle; a following cond=000 branch waits in WAIT_FLAGS until new flags arrive.
REQ-045 rst_n pulsed low in EVAL -> all outputs 0 asynchronously and no out_valid after release; cond=111 with flags {0,0,0} afterwards -> taken=1.

Source files
------------

// File: rtl/branch_cond_unit_if.sv
// Handshake/data bundle between ALU flags, branch issue, result consumer and the branch condition unit.
// The slave modport is the unit side; the master modport is the driver/consumer side.
interface branch_cond_unit_if #(
    parameter int PC_W = 32
);
    logic            flag_valid;
    logic            flag_ready;
    logic            rel_in;
    logic            n_in;
    logic            z_in;
    logic            br_valid;
    logic            br_ready;
    logic [2:0]      br_cond;
    logic [PC_W-1:0] br_target;
    logic [PC_W-1:0] pc_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic            taken;
    logic [PC_W-1:0] next_pc;
    logic [2:0]      flags_q;

    modport slave (
        input  flag_valid, rel_in, n_in, z_in,
        input  br_valid, br_cond, br_target, pc_in,
        input  flush, out_ready,
        output flag_ready, br_ready, out_valid, taken, next_pc, flags_q
    );

    modport master (
        output flag_valid, rel_in, n_in, z_in,
        output br_valid, br_cond, br_target, pc_in,
        output flush, out_ready,
        input  flag_ready, br_ready, out_valid, taken, next_pc, flags_q
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Resolves a conditional branch against stored ALU flags; result valid one cycle after the EVAL cycle.
// Takes one branch at a time: br_ready only in IDLE, result held in HOLD until out_ready.
module branch_cond_unit #(
    parameter int PC_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    branch_cond_unit_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, EVAL, HOLD} state_t;

    localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

    state_t          r_state;
    logic [2:0]      r_flags_q;
    logic            r_flags_vld;
    logic [2:0]      r_cond;
    logic [PC_W-1:0] r_target;
    logic [PC_W-1:0] r_pc;
    logic            r_out_valid;
    logic            r_taken;
    logic [PC_W-1:0] r_next_pc;

    logic w_flag_hs;
    logic w_br_hs;
    logic w_cond_true;

    assign bus.br_ready   = (r_state == IDLE);
    assign bus.flag_ready = (r_state == IDLE) || (r_state == WAIT_FLAGS);
    assign bus.out_valid  = r_out_valid;
    assign bus.taken      = r_taken;
    assign bus.next_pc    = r_next_pc;
    assign bus.flags_q    = r_flags_q;

    assign w_flag_hs = bus.flag_valid && bus.flag_ready;
    assign w_br_hs   = bus.br_valid && bus.br_ready;

    // r_flags_q is {rel, n, z}
    always_comb begin
        w_cond_true = 1'b0;
        case (r_cond)
            3'b000: w_cond_true = 1'b1;
            3'b001: w_cond_true = 1'b0;
            3'b010: w_cond_true = r_flags_q[2];
            3'b011: w_cond_true = !r_flags_q[2];
            3'b100: w_cond_true = r_flags_q[0];
            3'b101: w_cond_true = !r_flags_q[0];
            3'b110: w_cond_true = r_flags_q[1];
            3'b111: w_cond_true = !r_flags_q[1] && !r_flags_q[0];
            default: w_cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_flags_q   <= 3'b000;
            r_flags_vld <= 1'b0;
            r_cond      <= 3'b000;
            r_target    <= '0;
            r_pc        <= '0;
            r_out_valid <= 1'b0;
            r_taken     <= 1'b0;
            r_next_pc   <= '0;
        end else if (bus.flush) begin
            // Abort wins over any handshake; last result and flags stay visible.
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_flags_vld <= 1'b0;
        end else begin
            if (w_flag_hs) begin
                r_flags_q   <= {bus.rel_in, bus.n_in, bus.z_in};
                r_flags_vld <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_br_hs) begin
                        r_cond   <= bus.br_cond;
                        r_target <= bus.br_target;
                        r_pc     <= bus.pc_in;
                        r_state  <= (r_flags_vld || w_flag_hs) ? EVAL : WAIT_FLAGS;
                    end
                end
                WAIT_FLAGS: begin
                    if (w_flag_hs) r_state <= EVAL;
                end
                EVAL: begin
                    r_taken     <= w_cond_true;
                    r_next_pc   <= w_cond_true ? r_target : (r_pc + PC_INC);
                    r_out_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
